// File: rtl/crt_mem_arbiter_pkg.sv
// Shared state encoding, return-tag values and a saturating counter helper
// for the CRT/CPU frame-buffer memory arbiter.
package crt_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_VID  = 2'd1,
        ST_CPU  = 2'd2
    } state_t;

    localparam logic TAG_VID = 1'b0;
    localparam logic TAG_CPU = 1'b1;

    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : value + 16'd1;
    endfunction

endpackage

// File: rtl/crt_tag_fifo.sv
// One-bit tag FIFO that remembers which port issued each outstanding read.
// The head is readable combinationally so the return path adds no latency.
module crt_tag_fifo #(
    parameter int DEPTH = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic push,
    input  logic din,
    input  logic pop,
    output logic dout,
    output logic full,
    output logic empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic [DEPTH-1:0] store_reg;
    logic [DEPTH-1:0] wr_en;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
    endfunction

    assign full    = (count_reg == CNT_W'(DEPTH));
    assign empty   = (count_reg == '0);
    assign do_pop  = pop & ~empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO is still taken.
    assign do_push = push & (~full | do_pop);
    assign dout    = store_reg[rd_ptr_reg];

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_slot
            assign wr_en[gi] = do_push & (wr_ptr_reg == PTR_W'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (wr_en[i]) begin
                store_reg[i] <= din;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= ptr_inc(wr_ptr_reg);
            end
            if (do_pop) begin
                rd_ptr_reg <= ptr_inc(rd_ptr_reg);
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/crt_mem_arbiter.sv
// Shares one in-order memory port between CRT burst reads and CPU single accesses.
// Define CRT_ARB_STATS_EN to build the urgent-grant and CPU-wait statistics counters.
module crt_mem_arbiter
    import crt_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 16,
    parameter int BURST_LEN = 8,
    parameter int MAX_OUT   = 16,
    parameter int LEVEL_W   = 8,
    parameter int LOW_WATER = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    input  logic [LEVEL_W-1:0] vid_level,
    output logic              vid_ack,
    output logic              vid_rvalid,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              err,
    output logic [15:0]       stat_urgent,
    output logic [15:0]       stat_cpu_wait
);

    localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

    state_t            state_reg;
    state_t            state_next;
    logic [BEAT_W-1:0] beat_reg;
    logic              rr_last_reg;
    logic              err_reg;

    logic              urgent;
    logic              grant_vid;
    logic              grant_cpu;
    logic              last_beat;
    logic              read_ok;
    logic              accept;
    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_head;
    logic              push_tag;

    assign urgent    = vid_req & (32'(vid_level) < LOW_WATER);
    assign last_beat = (beat_reg == BEAT_W'(BURST_LEN - 1));
    assign read_ok   = ~fifo_full;

    // Arbitration is only meaningful in IDLE; an open burst is never preempted.
    always_comb begin
        grant_vid = 1'b0;
        grant_cpu = 1'b0;
        if (state_reg == ST_IDLE) begin
            if (urgent) begin
                grant_vid = 1'b1;
            end else if (vid_req && cpu_req) begin
                if (rr_last_reg == TAG_CPU) begin
                    grant_vid = 1'b1;
                end else begin
                    grant_cpu = 1'b1;
                end
            end else if (vid_req) begin
                grant_vid = 1'b1;
            end else if (cpu_req) begin
                grant_cpu = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (grant_vid) begin
                    state_next = ST_VID;
                end else if (grant_cpu) begin
                    state_next = ST_CPU;
                end
            end
            ST_VID: begin
                if (accept && last_beat) begin
                    state_next = ST_IDLE;
                end
            end
            ST_CPU: begin
                if (accept) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Command outputs depend only on state and held request inputs, so they
    // cannot change while the memory is stalling an offered command.
    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state_reg)
            ST_VID: begin
                mem_req  = read_ok;
                mem_addr = vid_addr + ADDR_W'(beat_reg);
            end
            ST_CPU: begin
                mem_req   = cpu_we | read_ok;
                mem_we    = cpu_we;
                mem_addr  = cpu_addr;
                mem_wdata = cpu_wdata;
            end
            default: ;
        endcase
    end

    assign accept    = mem_req & mem_ready;
    assign vid_ack   = (state_reg == ST_VID) & accept & last_beat;
    assign cpu_ack   = (state_reg == ST_CPU) & accept;
    assign fifo_push = accept & ~mem_we;
    assign push_tag  = (state_reg == ST_CPU) ? TAG_CPU : TAG_VID;
    assign fifo_pop  = mem_rvalid & ~fifo_empty;

    always_ff @(posedge clk) begin
        if (!reset) begin
            beat_reg    <= '0;
            rr_last_reg <= TAG_CPU;
            err_reg     <= 1'b0;
        end else begin
            if (state_reg == ST_VID && accept) begin
                beat_reg <= last_beat ? '0 : beat_reg + BEAT_W'(1);
            end
            if (grant_vid) begin
                rr_last_reg <= TAG_VID;
            end else if (grant_cpu) begin
                rr_last_reg <= TAG_CPU;
            end
            if (mem_rvalid && fifo_empty) begin
                err_reg <= 1'b1;
            end
        end
    end

    crt_tag_fifo #(
        .DEPTH (MAX_OUT)
    ) u_tag_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .din   (push_tag),
        .pop   (fifo_pop),
        .dout  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign rdata      = mem_rdata;
    assign vid_rvalid = fifo_pop & (fifo_head == TAG_VID);
    assign cpu_rvalid = fifo_pop & (fifo_head == TAG_CPU);
    assign err        = err_reg;

`ifdef CRT_ARB_STATS_EN
    logic [15:0] stat_urgent_reg;
    logic [15:0] stat_cpu_wait_reg;

    always_ff @(posedge clk) begin
        if (!reset) begin
            stat_urgent_reg   <= '0;
            stat_cpu_wait_reg <= '0;
        end else begin
            if (state_reg == ST_IDLE && urgent) begin
                stat_urgent_reg <= sat_inc16(stat_urgent_reg);
            end
            if (cpu_req && !cpu_ack) begin
                stat_cpu_wait_reg <= sat_inc16(stat_cpu_wait_reg);
            end
        end
    end

    assign stat_urgent   = stat_urgent_reg;
    assign stat_cpu_wait = stat_cpu_wait_reg;
`else
    assign stat_urgent   = '0;
    assign stat_cpu_wait = '0;
`endif

endmodule

// File: tb/tb_crt_mem_arbiter.sv
// Randomized and directed bench for crt_mem_arbiter with a transaction-level
// reference model (port ownership, beat index, and a queue of outstanding tags).
module tb_crt_mem_arbiter;

    localparam int ADDR_W    = 32;
    localparam int DATA_W    = 16;
    localparam int BURST_LEN = 8;
    localparam int MAX_OUT   = 16;
    localparam int LEVEL_W   = 8;
    localparam int LOW_WATER = 16;
    localparam int P_NONE    = 0;
    localparam int P_VID     = 1;
    localparam int P_CPU     = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic              vid_req;
    logic [ADDR_W-1:0] vid_addr;
    logic [LEVEL_W-1:0] vid_level;
    logic              vid_ack;
    logic              vid_rvalid;
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_ack;
    logic              cpu_rvalid;
    logic [DATA_W-1:0] rdata;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ready;
    logic              mem_rvalid;
    logic [DATA_W-1:0] mem_rdata;
    logic              err;
    logic [15:0]       stat_urgent;
    logic [15:0]       stat_cpu_wait;

    always #5 clk = ~clk;

    crt_mem_arbiter #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .BURST_LEN (BURST_LEN),
        .MAX_OUT   (MAX_OUT),
        .LEVEL_W   (LEVEL_W),
        .LOW_WATER (LOW_WATER)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .vid_req       (vid_req),
        .vid_addr      (vid_addr),
        .vid_level     (vid_level),
        .vid_ack       (vid_ack),
        .vid_rvalid    (vid_rvalid),
        .cpu_req       (cpu_req),
        .cpu_we        (cpu_we),
        .cpu_addr      (cpu_addr),
        .cpu_wdata     (cpu_wdata),
        .cpu_ack       (cpu_ack),
        .cpu_rvalid    (cpu_rvalid),
        .rdata         (rdata),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_ready     (mem_ready),
        .mem_rvalid    (mem_rvalid),
        .mem_rdata     (mem_rdata),
        .err           (err),
        .stat_urgent   (stat_urgent),
        .stat_cpu_wait (stat_cpu_wait)
    );

    // Reference model state: who owns the port, which beat is next, outstanding read tags.
    int   m_port;
    int   m_beat;
    bit   m_rr_cpu;
    bit   tagq[$];
    bit   m_err;
    int   m_stat_urg;
    int   m_stat_wait;
    bit   model_valid;
    bit   ev_vid_ack;
    bit   ev_cpu_ack;

    int   n_checks;
    int   n_fail;
    int   cycle;

    logic [31:0] addr_log[$];
    bit          ack_log[$];
    int          n_vid_rv;

    // Stimulus knobs.
    bit   vid_want;
    int   cpu_left;
    int   cpu_we_mode;
    int   ready_pct;
    int   rv_pct;
    bit   rand_level;
    bit   rand_vaddr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40) begin
                $display("FAIL %s at cycle %0d: got %h, expected %h", name, cycle, act, exp);
            end
        end
    endtask

    always @(negedge clk) begin : compare
        bit          exp_req;
        bit          exp_we;
        bit          exp_vack;
        bit          exp_cack;
        bit          exp_vrv;
        bit          exp_crv;
        bit          acc;
        logic [31:0] exp_addr;
        logic [15:0] exp_wdata;

        cycle++;
        exp_req   = 1'b0;
        exp_we    = 1'b0;
        exp_vrv   = 1'b0;
        exp_crv   = 1'b0;
        exp_addr  = '0;
        exp_wdata = '0;
        if (m_port == P_VID) begin
            exp_req  = (tagq.size() < MAX_OUT);
            exp_addr = vid_addr + 32'(m_beat);
        end else if (m_port == P_CPU) begin
            exp_req   = cpu_we || (tagq.size() < MAX_OUT);
            exp_we    = cpu_we;
            exp_addr  = cpu_addr;
            exp_wdata = cpu_wdata;
        end
        acc      = exp_req && mem_ready;
        exp_vack = (m_port == P_VID) && acc && (m_beat == BURST_LEN - 1);
        exp_cack = (m_port == P_CPU) && acc;
        if (mem_rvalid && tagq.size() > 0) begin
            exp_vrv = (tagq[0] == 1'b0);
            exp_crv = (tagq[0] == 1'b1);
        end

        if (model_valid) begin
            chk("mem_req", 32'(mem_req), 32'(exp_req));
            chk("vid_ack", 32'(vid_ack), 32'(exp_vack));
            chk("cpu_ack", 32'(cpu_ack), 32'(exp_cack));
            chk("vid_rvalid", 32'(vid_rvalid), 32'(exp_vrv));
            chk("cpu_rvalid", 32'(cpu_rvalid), 32'(exp_crv));
            chk("err", 32'(err), 32'(m_err));
            if (exp_req) begin
                chk("mem_addr", mem_addr, exp_addr);
                chk("mem_we", 32'(mem_we), 32'(exp_we));
                if (exp_we) begin
                    chk("mem_wdata", 32'(mem_wdata), 32'(exp_wdata));
                end
            end
            if (exp_vrv || exp_crv) begin
                chk("rdata", 32'(rdata), 32'(mem_rdata));
            end
`ifdef CRT_ARB_STATS_EN
            chk("stat_urgent", 32'(stat_urgent), 32'(m_stat_urg));
            chk("stat_cpu_wait", 32'(stat_cpu_wait), 32'(m_stat_wait));
`else
            chk("stat_urgent", 32'(stat_urgent), 32'd0);
            chk("stat_cpu_wait", 32'(stat_cpu_wait), 32'd0);
`endif
            if (mem_req && mem_ready) begin
                addr_log.push_back(mem_addr);
            end
            if (vid_ack) begin
                ack_log.push_back(1'b0);
                $display("cycle %0d: vid burst done, last addr %h", cycle, mem_addr);
            end
            if (cpu_ack) begin
                ack_log.push_back(1'b1);
                $display("cycle %0d: cpu %s addr %h", cycle, mem_we ? "write" : "read", mem_addr);
            end
            if (vid_rvalid) begin
                n_vid_rv++;
            end
        end

        ev_vid_ack = exp_vack;
        ev_cpu_ack = exp_cack;

        if (!reset) begin
            m_port      = P_NONE;
            m_beat      = 0;
            m_rr_cpu    = 1'b1;
            tagq.delete();
            m_err       = 1'b0;
            m_stat_urg  = 0;
            m_stat_wait = 0;
            model_valid = 1'b1;
        end else begin
            if (cpu_req && !exp_cack && m_stat_wait < 65535) begin
                m_stat_wait++;
            end
            if (mem_rvalid) begin
                if (tagq.size() > 0) begin
                    void'(tagq.pop_front());
                end else begin
                    m_err = 1'b1;
                end
            end
            if (acc && !exp_we) begin
                tagq.push_back(m_port == P_CPU);
            end
            case (m_port)
                P_VID: begin
                    if (acc) begin
                        if (m_beat == BURST_LEN - 1) begin
                            m_port = P_NONE;
                            m_beat = 0;
                        end else begin
                            m_beat++;
                        end
                    end
                end
                P_CPU: begin
                    if (acc) begin
                        m_port = P_NONE;
                    end
                end
                default: begin
                    if (vid_req && vid_level < LOW_WATER) begin
                        m_port   = P_VID;
                        m_rr_cpu = 1'b0;
                        if (m_stat_urg < 65535) begin
                            m_stat_urg++;
                        end
                    end else if (vid_req && cpu_req) begin
                        m_port   = m_rr_cpu ? P_VID : P_CPU;
                        m_rr_cpu = !m_rr_cpu;
                    end else if (vid_req) begin
                        m_port   = P_VID;
                        m_rr_cpu = 1'b0;
                    end else if (cpu_req) begin
                        m_port   = P_CPU;
                        m_rr_cpu = 1'b1;
                    end
                end
            endcase
        end
    end

    task automatic update_drivers();
        if (vid_req && ev_vid_ack) begin
            vid_req = 1'b0;
        end
        if (cpu_req && ev_cpu_ack) begin
            cpu_req = 1'b0;
            if (cpu_left > 0) begin
                cpu_left--;
            end
        end
        if (!vid_req && vid_want) begin
            vid_req = 1'b1;
            if (rand_vaddr) begin
                vid_addr = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : $urandom;
            end
        end
        if (!cpu_req && cpu_left > 0) begin
            cpu_req   = 1'b1;
            cpu_we    = (cpu_we_mode == 2) ? 1'($urandom_range(0, 1)) : 1'(cpu_we_mode);
            cpu_addr  = $urandom;
            cpu_wdata = 16'($urandom);
        end
        if (rand_level) begin
            vid_level = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 15))
                                                     : 8'($urandom_range(16, 255));
        end
        mem_ready  = ($urandom_range(0, 99) < ready_pct);
        mem_rvalid = (tagq.size() > 0) && ($urandom_range(0, 99) < rv_pct);
        mem_rdata  = 16'($urandom);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        update_drivers();
    endtask

    task automatic do_reset();
        vid_req  = 1'b0;
        cpu_req  = 1'b0;
        vid_want = 1'b0;
        cpu_left = 0;
        reset    = 1'b0;
        repeat (2) tick();
        reset = 1'b1;
        addr_log.delete();
        ack_log.delete();
        n_vid_rv = 0;
    endtask

    function automatic int cpu_ack_count();
        int n = 0;
        foreach (ack_log[i]) begin
            if (ack_log[i]) n++;
        end
        return n;
    endfunction

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        cycle       = 0;
        model_valid = 1'b0;
        m_port      = P_NONE;
        m_beat      = 0;
        m_rr_cpu    = 1'b1;
        m_err       = 1'b0;
        m_stat_urg  = 0;
        m_stat_wait = 0;
        n_vid_rv    = 0;
        rand_level  = 1'b0;
        rand_vaddr  = 1'b0;
        ready_pct   = 100;
        rv_pct      = 100;
        vid_want    = 1'b0;
        cpu_we_mode = 0;
        cpu_left    = 1;
        reset       = 1'b0;
        vid_req     = 1'b1;
        vid_addr    = 32'h0000_0100;
        vid_level   = 8'd200;
        cpu_req     = 1'b1;
        cpu_we      = 1'b0;
        cpu_addr    = 32'h0000_2000;
        cpu_wdata   = 16'h0;
        mem_ready   = 1'b1;
        mem_rvalid  = 1'b0;
        mem_rdata   = 16'h0;

        // Reset held with both ports requesting.
        repeat (3) tick();
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_vid_ack", 32'(vid_ack), 32'd0);
        chk("rst_cpu_ack", 32'(cpu_ack), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        addr_log.delete();
        ack_log.delete();
        n_vid_rv = 0;
        reset = 1'b1;

        // First grant is the burst at 0x100, then the waiting CPU read.
        repeat (30) tick();
        chk("burst_accepts", 32'(addr_log.size()), 32'd9);
        for (int i = 0; i < 8; i++) begin
            chk("burst_addr", addr_log[i], 32'h100 + 32'(i));
        end
        chk("burst_cpu_addr", addr_log[8], 32'h2000);
        chk("burst_ack_n", 32'(ack_log.size()), 32'd2);
        chk("burst_ack0", 32'(ack_log[0]), 32'd0);
        chk("burst_ack1", 32'(ack_log[1]), 32'd1);
        chk("burst_vid_rv", 32'(n_vid_rv), 32'd8);

        // Round-robin with both ports continuously requesting.
        do_reset();
        vid_want    = 1'b1;
        cpu_left    = 2;
        cpu_we_mode = 2;
        for (int i = 0; i < 200 && ack_log.size() < 4; i++) begin
            tick();
        end
        chk("rr_n", 32'(ack_log.size() >= 4), 32'd1);
        chk("rr_0", 32'(ack_log[0]), 32'd0);
        chk("rr_1", 32'(ack_log[1]), 32'd1);
        chk("rr_2", 32'(ack_log[2]), 32'd0);
        chk("rr_3", 32'(ack_log[3]), 32'd1);
        vid_want = 1'b0;
        cpu_left = 0;
        repeat (40) tick();

        // Urgency overrides round-robin after a video grant.
        do_reset();
        vid_addr  = 32'h0000_4000;
        vid_level = 8'd200;
        vid_req   = 1'b1;
        repeat (15) tick();
        vid_level = 8'd3;
        vid_req   = 1'b1;
        cpu_req   = 1'b1;
        cpu_we    = 1'b0;
        cpu_addr  = 32'h0000_5000;
        cpu_left  = 1;
        repeat (30) tick();
        chk("urg_n", 32'(ack_log.size()), 32'd3);
        chk("urg_0", 32'(ack_log[0]), 32'd0);
        chk("urg_1", 32'(ack_log[1]), 32'd0);
        chk("urg_2", 32'(ack_log[2]), 32'd1);
`ifdef CRT_ARB_STATS_EN
        chk("urg_stat", 32'(stat_urgent), 32'd1);
`else
        chk("urg_stat", 32'(stat_urgent), 32'd0);
`endif
        vid_level = 8'd200;

        // Tag FIFO full: sixteen reads outstanding, a write still goes, the next read stalls.
        do_reset();
        rv_pct      = 0;
        cpu_we_mode = 0;
        cpu_left    = 16;
        repeat (40) tick();
        chk("full_reads", 32'(cpu_ack_count()), 32'd16);
        cpu_we_mode = 1;
        cpu_left    = 1;
        repeat (5) tick();
        chk("full_write", 32'(cpu_ack_count()), 32'd17);
        cpu_we_mode = 0;
        cpu_left    = 1;
        repeat (6) tick();
        chk("full_stall_req", 32'(mem_req), 32'd0);
        chk("full_stall_ack", 32'(cpu_ack_count()), 32'd17);
        mem_rvalid = 1'b1;
        repeat (4) tick();
        chk("full_resume", 32'(cpu_ack_count()), 32'd18);
        rv_pct   = 100;
        cpu_left = 0;
        repeat (40) tick();

        // Randomized traffic.
        rand_level  = 1'b1;
        rand_vaddr  = 1'b1;
        cpu_we_mode = 2;
        for (int c = 0; c < 2400; c++) begin
            if (c % 200 == 0) begin
                case ($urandom_range(0, 2))
                    0:       ready_pct = 100;
                    1:       ready_pct = 70;
                    default: ready_pct = 30;
                endcase
                case ($urandom_range(0, 2))
                    0:       rv_pct = 80;
                    1:       rv_pct = 40;
                    default: rv_pct = 5;
                endcase
            end
            vid_want = ($urandom_range(0, 99) < 70);
            if (cpu_left == 0 && $urandom_range(0, 99) < 30) begin
                cpu_left = 1;
            end
            tick();
        end
        vid_want   = 1'b0;
        cpu_left   = 0;
        rand_level = 1'b0;
        vid_level  = 8'd200;
        ready_pct  = 100;
        rv_pct     = 100;
        repeat (80) tick();

        // Return with nothing outstanding sets a sticky error until reset.
        chk("err_before", 32'(err), 32'd0);
        mem_rvalid = 1'b1;
        repeat (5) tick();
        chk("err_sticky", 32'(err), 32'd1);
        do_reset();
        tick();
        chk("err_cleared", 32'(err), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
